// File: rtl/mnist_img_pkg.sv
// Shared constants and types for the 28x28 classifier image path.
package mnist_img_pkg;

  localparam int unsigned IMG_DIM    = 28;
  localparam int unsigned IMG_PIXELS = IMG_DIM * IMG_DIM;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned BLK_W      = 5;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } ds_state_t;

  // Row-major RAM address of block (by, bx).
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [BLK_W-1:0] by,
                                                 input logic [BLK_W-1:0] bx);
    return ADDR_W'(by) * ADDR_W'(IMG_DIM) + ADDR_W'(bx);
  endfunction

endpackage

// File: rtl/pixel_downsampler_if.sv
// Pixel stream in, classifier RAM write port and status out.
interface pixel_downsampler_if;
  import mnist_img_pkg::*;

  logic               iSTART;
  logic               iFRAME_START;
  logic               iPIX_VALID;
  logic [COORD_W-1:0] iX;
  logic [COORD_W-1:0] iY;
  pix_t               iPIX;
  logic               oWR_EN;
  logic [ADDR_W-1:0]  oWR_ADDR;
  pix_t               oWR_DATA;
  logic               oBUSY;
  logic               oDONE;

  modport master (
    output iSTART, iFRAME_START, iPIX_VALID, iX, iY, iPIX,
    input  oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE
  );

  modport slave (
    input  iSTART, iFRAME_START, iPIX_VALID, iX, iY, iPIX,
    output oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE
  );

endinterface

// File: rtl/col_accum_bank.sv
// One accumulator per output column; a block's first pixel reloads its slot,
// so no clear cycle is needed between block rows.
module col_accum_bank
  import mnist_img_pkg::*;
#(
  parameter int unsigned  SCALE = 8,
  localparam int unsigned ACC_W = PIX_W + 2 * $clog2(SCALE)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             load_i,
  input  logic             add_i,
  input  logic [BLK_W-1:0] bx_i,
  input  pix_t             pix_i,
  output logic [ACC_W-1:0] sum_o
);

  logic [ACC_W-1:0] acc_q [IMG_DIM];
  logic [ACC_W-1:0] acc_d [IMG_DIM];

  assign sum_o = acc_q[bx_i] + ACC_W'(pix_i);

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d[bx_i] = ACC_W'(pix_i);
    end else if (add_i) begin
      acc_d[bx_i] = sum_o;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < int'(IMG_DIM); i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pixel_downsampler.sv
// Crops a 28*SCALE window from the VGA pixel stream, box-averages each
// SCALE x SCALE block and writes the 28x28 result into the classifier RAM.
module pixel_downsampler
  import mnist_img_pkg::*;
#(
  parameter int unsigned X0    = 208,
  parameter int unsigned Y0    = 128,
  parameter int unsigned SCALE = 8
) (
  input logic                iCLK,
  input logic                iRST,
  pixel_downsampler_if.slave bus
);

  localparam int unsigned SH    = $clog2(SCALE);
  localparam int unsigned WIN   = IMG_DIM * SCALE;
  localparam int unsigned ACC_W = PIX_W + 2 * SH;
  localparam int unsigned XW    = COORD_W + 1;

  ds_state_t         state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  pix_t              wr_data_q, wr_data_d;

  logic [XW-1:0]      x_ext, y_ext;
  logic [COORD_W-1:0] dx, dy;
  logic [BLK_W-1:0]   bx, by;
  logic               in_win, cap_go, hit;
  logic               first_px, last_px;
  logic               acc_load, acc_add;
  logic [ACC_W-1:0]   blk_sum;

  // Window decode and block offsets.
  always_comb begin
    x_ext    = {1'b0, bus.iX};
    y_ext    = {1'b0, bus.iY};
    in_win   = bus.iPIX_VALID &&
               (x_ext >= XW'(X0)) && (x_ext < XW'(X0 + WIN)) &&
               (y_ext >= XW'(Y0)) && (y_ext < XW'(Y0 + WIN));
    dx       = bus.iX - COORD_W'(X0);
    dy       = bus.iY - COORD_W'(Y0);
    bx       = BLK_W'(dx >> SH);
    by       = BLK_W'(dy >> SH);
    first_px = (dx[SH-1:0] == '0) && (dy[SH-1:0] == '0);
    last_px  = (&dx[SH-1:0]) && (&dy[SH-1:0]);
    // A frame start in ARMED opens the capture for the coincident pixel too.
    cap_go   = (state_q == CAPTURE) || ((state_q == ARMED) && bus.iFRAME_START);
    hit      = cap_go && in_win;
    acc_load = hit && first_px;
    acc_add  = hit && !first_px;
  end

  col_accum_bank #(
    .SCALE (SCALE)
  ) u_bank (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .load_i (acc_load),
    .add_i  (acc_add),
    .bx_i   (bx),
    .pix_i  (bus.iPIX),
    .sum_o  (blk_sum)
  );

  always_comb begin
    wr_en_d   = hit && last_px;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = blk_addr(by, bx);
      wr_data_d = PIX_W'(blk_sum >> (2 * SH));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.iSTART) state_d = ARMED;
      ARMED:   if (bus.iFRAME_START) state_d = CAPTURE;
      // A frame start takes priority: the old pass is abandoned without oDONE.
      CAPTURE: if (!bus.iFRAME_START && wr_en_q &&
                   (wr_addr_q == ADDR_W'(IMG_PIXELS - 1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.oWR_EN   = wr_en_q;
  assign bus.oWR_ADDR = wr_addr_q;
  assign bus.oWR_DATA = wr_data_q;
  assign bus.oBUSY    = (state_q == ARMED) || (state_q == CAPTURE);
  assign bus.oDONE    = (state_q == DONE);

endmodule

// File: tb/tb_pixel_downsampler.sv
// Scoreboard bench: the driver pushes expected block averages computed from
// the frame image; an independent monitor pops and compares on each write.
module tb_pixel_downsampler;
  import mnist_img_pkg::*;

  // Small SCALE keeps each cropped raster at a few thousand cycles.
  localparam int X0    = 208;
  localparam int Y0    = 128;
  localparam int SCALE = 2;
  localparam int WIN   = 28 * SCALE;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   exp_done_cyc = -1;
  int   outval = 0;
  int   img [WIN][WIN];
  int   seen [784];
  exp_t sb_q [$];

  pixel_downsampler_if bus ();

  pixel_downsampler #(
    .X0    (X0),
    .Y0    (Y0),
    .SCALE (SCALE)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int block_avg(input int by, input int bx);
    int s = 0;
    for (int r = 0; r < SCALE; r++)
      for (int c = 0; c < SCALE; c++)
        s += img[by * SCALE + r][bx * SCALE + c];
    return s / (SCALE * SCALE);
  endfunction

  task automatic fill(input int mode);
    for (int dy = 0; dy < WIN; dy++) begin
      for (int dx = 0; dx < WIN; dx++) begin
        case (mode)
          0: img[dy][dx] = 255;
          1: img[dy][dx] = (dy < SCALE / 2 && dx < SCALE) ? 255 : 0;
          2: img[dy][dx] = (dy >= WIN - SCALE && dx >= WIN - SCALE &&
                            !(dy == WIN - SCALE && dx == WIN - SCALE + 1)) ? 255 : 0;
          3: img[dy][dx] = 0;
          default: img[dy][dx] = int'($urandom_range(255));
        endcase
      end
    end
    case (mode)
      0, 3:    outval = 255;
      1, 2:    outval = 0;
      default: outval = int'($urandom_range(255));
    endcase
  endtask

  // Raster covering the window plus a 2-pixel margin, with random idle gaps.
  task automatic drive_frame(input int max_wr, input bit exp_wr, input int start_at);
    int   nwr = 0;
    bit   first = 1'b1;
    bit   stop = 1'b0;
    bit   started = 1'b0;
    bit   in_w;
    int   dx;
    int   dy;
    exp_t e;
    @(posedge clk); #1;
    for (int y = Y0 - 2; y < Y0 + WIN + 2 && !stop; y++) begin
      for (int x = X0 - 2; x < X0 + WIN + 2 && !stop; x++) begin
        if (!first && $urandom_range(9) == 0) begin
          bus.iPIX_VALID   = 1'b0;
          bus.iSTART       = 1'b0;
          bus.iFRAME_START = 1'b0;
          @(posedge clk); #1;
        end
        dx = x - X0;
        dy = y - Y0;
        in_w = (dx >= 0) && (dx < WIN) && (dy >= 0) && (dy < WIN);
        bus.iFRAME_START = first;
        first = 1'b0;
        bus.iPIX_VALID = 1'b1;
        bus.iX = COORD_W'(x);
        bus.iY = COORD_W'(y);
        if (in_w) bus.iPIX = 8'(img[dy][dx]);
        else      bus.iPIX = 8'(outval);
        bus.iSTART = 1'b0;
        if (start_at >= 0 && nwr == start_at && !started) begin
          bus.iSTART = 1'b1;
          started = 1'b1;
        end
        if (exp_wr && in_w && (dx % SCALE == SCALE - 1) && (dy % SCALE == SCALE - 1)) begin
          e.addr = (dy / SCALE) * 28 + dx / SCALE;
          e.data = block_avg(dy / SCALE, dx / SCALE);
          e.cyc  = cyc + 1;
          sb_q.push_back(e);
          nwr++;
          if (e.addr == 783) exp_done_cyc = cyc + 2;
          if (nwr == max_wr) stop = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    bus.iPIX_VALID   = 1'b0;
    bus.iSTART       = 1'b0;
    bus.iFRAME_START = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.iSTART = 1'b1;
    @(posedge clk); #1;
    bus.iSTART = 1'b0;
    chk("busy_after_start", int'(bus.oBUSY), 1);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("busy_after_done", int'(bus.oBUSY), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, int'(bus.oWR_EN), 0);
    chk({tag, "_wr_addr"}, int'(bus.oWR_ADDR), 0);
    chk({tag, "_wr_data"}, int'(bus.oWR_DATA), 0);
    chk({tag, "_busy"}, int'(bus.oBUSY), 0);
    chk({tag, "_done"}, int'(bus.oDONE), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.oWR_EN) begin
          wr_cnt++;
          if (bus.oWR_ADDR < 10'd784) seen[bus.oWR_ADDR] = int'(bus.oWR_DATA);
          if (sb_q.size() == 0) begin
            chk("unexpected_write_addr", int'(bus.oWR_ADDR), -1);
          end else begin
            e = sb_q.pop_front();
            chk("wr_addr", int'(bus.oWR_ADDR), e.addr);
            chk("wr_data", int'(bus.oWR_DATA), e.data);
            chk("wr_cycle", cyc, e.cyc);
          end
        end
        if (bus.oDONE || cyc == exp_done_cyc) begin
          chk("done_pulse", int'(bus.oDONE), int'(cyc == exp_done_cyc));
          if (cyc == exp_done_cyc) exp_done_cyc = -1;
          if (bus.oDONE) begin
            done_cnt++;
            chk("busy_low_at_done", int'(bus.oBUSY), 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion",
             checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    int w0;
    int d0;
    bus.iSTART       = 1'b0;
    bus.iFRAME_START = 1'b0;
    bus.iPIX_VALID   = 1'b0;
    bus.iX           = '0;
    bus.iY           = '0;
    bus.iPIX         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Frames without iSTART produce nothing.
    fill(0);
    w0 = wr_cnt; d0 = done_cnt;
    drive_frame(784, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_writes", wr_cnt - w0, 0);
    chk("idle_done", done_cnt - d0, 0);

    // Uniform frame with a stray iSTART mid-capture.
    pulse_start();
    w0 = wr_cnt; d0 = done_cnt;
    drive_frame(784, 1'b1, 300);
    wait_done(d0);
    chk("uniform_write_count", wr_cnt - w0, 784);

    pulse_start();
    fill(1);
    d0 = done_cnt;
    drive_frame(784, 1'b1, -1);
    wait_done(d0);
    chk("block00_half", seen[0], 127);

    pulse_start();
    fill(2);
    d0 = done_cnt;
    drive_frame(784, 1'b1, -1);
    wait_done(d0);
    chk("block2727_one_zero", seen[783], 191);

    pulse_start();
    fill(3);
    d0 = done_cnt;
    drive_frame(784, 1'b1, -1);
    wait_done(d0);

    pulse_start();
    fill(4);
    d0 = done_cnt;
    drive_frame(784, 1'b1, -1);
    wait_done(d0);

    // Frame start after 300 writes restarts the pass from address 0.
    pulse_start();
    fill(4);
    w0 = wr_cnt; d0 = done_cnt;
    drive_frame(300, 1'b1, -1);
    chk("busy_mid_capture", int'(bus.oBUSY), 1);
    fill(4);
    drive_frame(784, 1'b1, -1);
    wait_done(d0);
    chk("restart_write_count", wr_cnt - w0, 1084);

    // Reset right after write 500 abandons the frame.
    pulse_start();
    fill(4);
    d0 = done_cnt;
    drive_frame(500, 1'b1, -1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_drained", sb_q.size(), 0);

    fill(0);
    w0 = wr_cnt;
    drive_frame(784, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_idle_writes", wr_cnt - w0, 0);

    pulse_start();
    fill(4);
    d0 = done_cnt;
    drive_frame(784, 1'b1, -1);
    wait_done(d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_downsampler.md
Name: pixel_downsampler

Overview:
- Consumes the binarized/inverted 8-bit pixel stream produced by the contour stage, which is pixel-synchronous with VGA scan coordinates.
- Crops a square window of 28*SCALE pixels, box-averages each SCALE x SCALE block, and writes the resulting 28x28 image into the classifier input RAM.
- One armed capture yields exactly one frame; oDONE hands control to the classifier.

Parameters:
- X0, 208, left column of the capture window in VGA coordinates.
- Y0, 128, top row of the capture window.
- SCALE, 8, block edge in pixels; must be a power of 2 (2..16). The window is 28*SCALE square.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous active-high reset.
- iSTART  in  1  single-cycle arm request.
- iFRAME_START  in  1  single-cycle pulse at the start of each VGA frame.
- iPIX_VALID  in  1  qualifies iPIX/iX/iY this cycle.
- iX  in  10  column of the current pixel.
- iY  in  10  row of the current pixel.
- iPIX  in  8  binarized pixel value (0..255).
- oWR_EN  out  1  RAM write strobe.
- oWR_ADDR  out  10  write address, row-major, 0..783.
- oWR_DATA  out  8  averaged pixel.
- oBUSY  out  1  high in ARMED and CAPTURE.
- oDONE  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators and counters cleared. Reset mid-capture abandons the frame; no oDONE is produced.
- States:
  - IDLE: iSTART moves to ARMED.
  - ARMED: iFRAME_START moves to CAPTURE.
  - CAPTURE: on the write of address 783, moves to DONE.
  - DONE: lasts one cycle, oDONE=1, then returns to IDLE.
- iSTART is ignored outside IDLE.
- iFRAME_START during CAPTURE restarts capture:
  - write index returns to 0;
  - accumulators reload on first use;
  - no oDONE is issued.
- A pixel is in the window iff iPIX_VALID && X0<=iX<X0+28*SCALE && Y0<=iY<Y0+28*SCALE. Pixels outside the window, and all pixels outside CAPTURE, are ignored.
- Offsets for an in-window pixel:
  - dx=iX-X0, dy=iY-Y0.
  - Column block bx=dx>>log2(SCALE); row block by=dy>>log2(SCALE).
  - ox=dx mod SCALE; oy=dy mod SCALE.
- Accumulator bank:
  - 28 accumulators, each ACC_W = 8+2*log2(SCALE) bits (14 for SCALE=8).
  - When oy==0 && ox==0, acc[bx] loads iPIX; no separate clear cycle is used.
  - Otherwise acc[bx] += iPIX. The sum cannot overflow ACC_W.
- Write-out: when oy==SCALE-1 && ox==SCALE-1, the cycle after that pixel:
  - oWR_EN=1;
  - oWR_ADDR=by*28+bx;
  - oWR_DATA=(acc[bx]+iPIX)>>(2*log2(SCALE)), truncated, no rounding.
- Latency is 1 cycle, pixel to write. At most one write per SCALE pixels, so no buffering or backpressure is required.
- oDONE asserts the cycle after the address-783 write. oBUSY drops in the same cycle oDONE rises.
- iFRAME_START coincident with a valid pixel: the restart takes effect first, and the pixel is processed in the new capture.
- iX/iY are taken as monotonic raster order within a frame. Coordinates out of order corrupt only the data, never the state machine.

Decomposition:
- Package mnist_img_pkg:
  - IMG_DIM=28, IMG_PIXELS=784, ADDR_W=10, PIX_W=8;
  - typedef pix_t (logic [7:0]);
  - enum ds_state_t {IDLE, ARMED, CAPTURE, DONE}.
- Sub-module col_accum_bank, parameterised by SCALE:
  - holds the 28 accumulators;
  - inputs: load, add, bx, pix;
  - output: sum of the selected accumulator plus pix.
- The top module keeps window decode, counters, FSM and output registers.

Test Plan (SCALE=8, X0=208, Y0=128, full 640x480 raster):
- Uniform 255 frame after iSTART + iFRAME_START -> 784 writes with addr 0..783 in order, all data 255; single oDONE one cycle after write 783; oBUSY high from iSTART to oDONE.
- Block (0,0) rows 0-3 =255, rows 4-7 =0, rest 0 -> addr 0 data 127; every other addr 0.
- Block (27,27) with 63 pixels 255 and one 0 -> addr 783 data 251 (16065>>6); write occurs 1 cycle after pixel (431,351).
- All pixels outside the window 255, inside 0 -> 784 writes of 0. Without iSTART -> zero writes and no oDONE.
- iSTART pulsed mid-CAPTURE is ignored. iFRAME_START at write 300 -> capture restarts at addr 0; oDONE only after a full 784-write pass.
- iRST asserted at write 500 -> all outputs 0 immediately; after release, no writes until a new iSTART + iFRAME_START.
